// File: rtl/mcp3208_if.sv
// rtl/mcp3208_if.sv - request/result handshake bundle between a client and mcp3208_reader
interface mcp3208_if;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_chan;
   logic        req_diff;
   logic        res_valid;
   logic [11:0] res_data;
   logic [2:0]  res_chan;
   logic        res_err;

   modport master (
      output req_valid, req_chan, req_diff,
      input  req_ready, res_valid, res_data, res_chan, res_err
   );

   modport slave (
      input  req_valid, req_chan, req_diff,
      output req_ready, res_valid, res_data, res_chan, res_err
   );
endinterface

// File: rtl/mcp3208_reader.sv
// rtl/mcp3208_reader.sv - SPI master returning one tagged MCP3208 conversion per request
// Optional null-bit check enabled by defining MCP3208_NULL_CHECK_EN.
module mcp3208_reader #(
   parameter int DIV    = 4,
   parameter int CS_GAP = 8
) (
   input  logic     clk,
   input  logic     rst_n,
   mcp3208_if.slave bus,
   output logic     adc_cs_n,
   output logic     adc_sclk,
   output logic     adc_din,
   input  logic     adc_dout
);
   typedef enum logic [1:0] {IDLE, FRAME, GAP} state_t;

   localparam logic [7:0] DIV_LAST  = 8'(DIV - 1);
   localparam logic [7:0] GAP_LAST  = 8'(CS_GAP - 1);
   localparam logic [5:0] LAST_HALF = 6'd39;

   state_t      state_q, state_d;
   logic [7:0]  div_q, div_d;
   logic [7:0]  gap_q, gap_d;
   logic [5:0]  half_q, half_d;
   logic [5:0]  half_nx;
   logic [4:0]  cmd_q, cmd_d;
   logic [2:0]  chan_q, chan_d;
   logic [11:0] shift_q, shift_d;
   logic        cs_n_q, cs_n_d;
   logic        sclk_q, sclk_d;
   logic        din_q, din_d;
   logic        ready_q, ready_d;
   logic        rv_q, rv_d;
   logic [11:0] rdata_q, rdata_d;
   logic [2:0]  rchan_q, rchan_d;
   logic        rerr_q, rerr_d;
`ifdef MCP3208_NULL_CHECK_EN
   logic        null_q, null_d;
`endif

   // Half-period index: SCLK is high on odd halves 1..37, CS releases on half 39.
   assign half_nx = half_q + 6'd1;

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      gap_d   = gap_q;
      half_d  = half_q;
      cmd_d   = cmd_q;
      chan_d  = chan_q;
      shift_d = shift_q;
      cs_n_d  = cs_n_q;
      sclk_d  = sclk_q;
      din_d   = din_q;
      ready_d = ready_q;
      rv_d    = 1'b0;
      rdata_d = rdata_q;
      rchan_d = rchan_q;
      rerr_d  = rerr_q;
`ifdef MCP3208_NULL_CHECK_EN
      null_d  = null_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.req_valid && ready_q) begin
               cmd_d   = {1'b1, ~bus.req_diff, bus.req_chan};
               chan_d  = bus.req_chan;
               cs_n_d  = 1'b0;
               din_d   = 1'b1;
               div_d   = 8'd0;
               half_d  = 6'd0;
               ready_d = 1'b0;
               state_d = FRAME;
            end
         end
         FRAME: begin
            // DOUT is captured in the first clk cycle of each SCLK high phase.
            if (half_q[0] && div_q == 8'd0) begin
               if (half_q >= 6'd15)
                  shift_d = {shift_q[10:0], adc_dout};
`ifdef MCP3208_NULL_CHECK_EN
               if (half_q == 6'd13)
                  null_d = (adc_dout !== 1'b0);
`endif
            end
            if (div_q == DIV_LAST) begin
               div_d  = 8'd0;
               half_d = half_nx;
               if (half_nx == LAST_HALF) begin
                  cs_n_d  = 1'b1;
                  sclk_d  = 1'b0;
                  din_d   = 1'b0;
                  rv_d    = 1'b1;
                  rdata_d = shift_q;
                  rchan_d = chan_q;
`ifdef MCP3208_NULL_CHECK_EN
                  rerr_d  = null_q;
`else
                  rerr_d  = 1'b0;
`endif
                  gap_d   = 8'd0;
                  state_d = GAP;
               end else begin
                  sclk_d = half_nx[0];
                  // Falling edge: next command bit; zeros shift in once the 5 bits are out.
                  if (!half_nx[0]) begin
                     din_d = cmd_q[3];
                     cmd_d = {cmd_q[3:0], 1'b0};
                  end
               end
            end else begin
               div_d = div_q + 8'd1;
            end
         end
         default: begin
            if (gap_q == GAP_LAST) begin
               ready_d = 1'b1;
               state_d = IDLE;
            end else begin
               gap_d = gap_q + 8'd1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= GAP;
         div_q   <= 8'd0;
         gap_q   <= 8'd0;
         half_q  <= 6'd0;
         cmd_q   <= 5'd0;
         chan_q  <= 3'd0;
         shift_q <= 12'd0;
         cs_n_q  <= 1'b1;
         sclk_q  <= 1'b0;
         din_q   <= 1'b0;
         ready_q <= 1'b0;
         rv_q    <= 1'b0;
         rdata_q <= 12'd0;
         rchan_q <= 3'd0;
         rerr_q  <= 1'b0;
`ifdef MCP3208_NULL_CHECK_EN
         null_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         gap_q   <= gap_d;
         half_q  <= half_d;
         cmd_q   <= cmd_d;
         chan_q  <= chan_d;
         shift_q <= shift_d;
         cs_n_q  <= cs_n_d;
         sclk_q  <= sclk_d;
         din_q   <= din_d;
         ready_q <= ready_d;
         rv_q    <= rv_d;
         rdata_q <= rdata_d;
         rchan_q <= rchan_d;
         rerr_q  <= rerr_d;
`ifdef MCP3208_NULL_CHECK_EN
         null_q  <= null_d;
`endif
      end
   end

   assign adc_cs_n      = cs_n_q;
   assign adc_sclk      = sclk_q;
   assign adc_din       = din_q;
   assign bus.req_ready = ready_q;
   assign bus.res_valid = rv_q;
   assign bus.res_data  = rdata_q;
   assign bus.res_chan  = rchan_q;
   assign bus.res_err   = rerr_q;
endmodule
